// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler: owns the obstacle pool for the lane game.
// It allocates slots, picks spawn lanes from an 8-bit LFSR, advances obstacles on
// accepted slow ticks, retires them past the bottom edge and keeps score and level.
// Build macro: DOUBLE_SPAWN_EN -- each spawn row fills two slots in distinct lanes.
module obstacle_spawn_scheduler #(
    parameter int         NUM_SLOTS   = 4,
    parameter int         Y_STEP_INIT = 4,
    parameter int         SPAWN_GAP   = 120,
    parameter int         Y_LIMIT     = 560,
    parameter int         PTS_PER_LVL = 8,
    parameter int         MAX_LEVEL   = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    run,
    input  logic                    clear,
    output logic [NUM_SLOTS-1:0]    obs_valid,
    output logic [2*NUM_SLOTS-1:0]  obs_lane,
    output logic [10*NUM_SLOTS-1:0] obs_y,
    output logic [15:0]             score,
    output logic [3:0]              level,
    output logic                    busy,
    output logic                    spawn_pls
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADVANCE = 2'd1,
        ST_SPAWN   = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [NUM_SLOTS-1:0]       valid_q, valid_d;
    logic [NUM_SLOTS-1:0][1:0]  lane_q, lane_d;
    logic [NUM_SLOTS-1:0][9:0]  y_q, y_d;
    logic [15:0]                score_q, score_d;
    logic [3:0]                 level_q, level_d;
    logic [15:0]                gap_q, gap_d;
    logic [7:0]                 lfsr_q, lfsr_d;
    logic [1:0]                 last_lane_q, last_lane_d;
    logic                       busy_q, busy_d;
    logic                       spawn_q, spawn_d;

    logic [4:0]                 step_s;
    logic [NUM_SLOTS-1:0][10:0] y_sum_s;
    logic [NUM_SLOTS-1:0]       retire_s;
    logic [3:0]                 retire_cnt_s;
    logic [16:0]                score_sum_s;
    logic [16:0]                gap_sum_s;
    logic [15:0]                lvl_raw_s;
    logic [IW-1:0]              first_free_s;
    logic                       has_free_s;
    logic [1:0]                 lane_pick_s;

    // Lane following the previous spawn lane, wrapping 2 -> 0.
    function automatic logic [1:0] next_lane(input logic [1:0] l);
        logic [1:0] n;
        case (l)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign step_s      = 5'(Y_STEP_INIT) + {1'b0, level_q};
    assign score_sum_s = {1'b0, score_q} + {13'd0, retire_cnt_s};
    assign gap_sum_s   = {1'b0, gap_q} + {12'd0, step_s};
    // LFSR value 3 is remapped so the lane distribution stays within 0..2.
    assign lane_pick_s = (lfsr_q[1:0] != 2'd3) ? lfsr_q[1:0] : next_lane(last_lane_q);

    // Per-slot advanced position, retirement flags and retired count.
    always_comb begin
        retire_cnt_s = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            y_sum_s[i]   = {1'b0, y_q[i]} + {6'd0, step_s};
            retire_s[i]  = valid_q[i] && (y_sum_s[i] >= 11'(Y_LIMIT));
            retire_cnt_s = retire_cnt_s + {3'd0, retire_s[i]};
        end
    end

    // Lowest-index free slot (scan downward so the lowest index wins).
    always_comb begin
        first_free_s = {IW{1'b0}};
        has_free_s   = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                first_free_s = IW'(i);
                has_free_s   = 1'b1;
            end else begin
                has_free_s   = has_free_s;
            end
        end
    end

`ifdef DOUBLE_SPAWN_EN
    logic [IW-1:0] second_free_s;
    logic          has_second_s;
    logic [1:0]    lane2_s;

    // Reduce a small value (0..7) modulo 3.
    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [1:0] m;
        if (v >= 3'd6) begin
            m = 2'(v - 3'd6);
        end else if (v >= 3'd3) begin
            m = 2'(v - 3'd3);
        end else begin
            m = v[1:0];
        end
        return m;
    endfunction

    // Second row lane is offset by 1 or 2, so it never matches the first lane.
    assign lane2_s = mod3({1'b0, lane_pick_s} + 3'd1 + {2'd0, lfsr_q[2]});

    // Second-lowest free slot for the paired obstacle.
    always_comb begin
        second_free_s = {IW{1'b0}};
        has_second_s  = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i] && (IW'(i) != first_free_s)) begin
                second_free_s = IW'(i);
                has_second_s  = 1'b1;
            end else begin
                has_second_s  = has_second_s;
            end
        end
    end
`endif

    // Next-state logic: clear wins, then IDLE/ADVANCE/SPAWN sequencing.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        y_d         = y_q;
        score_d     = score_q;
        level_d     = level_q;
        gap_d       = gap_q;
        lfsr_d      = lfsr_q;
        last_lane_d = last_lane_q;
        spawn_d     = 1'b0;
        lvl_raw_s   = 16'd0;
        if (clear) begin
            state_d     = ST_IDLE;
            valid_d     = {NUM_SLOTS{1'b0}};
            lane_d      = {(2*NUM_SLOTS){1'b0}};
            y_d         = {(10*NUM_SLOTS){1'b0}};
            score_d     = 16'd0;
            level_d     = 4'd0;
            gap_d       = 16'(SPAWN_GAP);
            lfsr_d      = LFSR_SEED;
            last_lane_d = 2'd1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && run) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADVANCE: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (retire_s[i]) begin
                            valid_d[i] = 1'b0;
                            y_d[i]     = 10'd0;
                        end else if (valid_q[i]) begin
                            y_d[i]     = y_sum_s[i][9:0];
                        end else begin
                            y_d[i]     = y_q[i];
                        end
                    end
                    score_d   = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
                    lvl_raw_s = score_d / 16'(PTS_PER_LVL);
                    level_d   = (lvl_raw_s >= 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : lvl_raw_s[3:0];
                    gap_d     = (gap_sum_s >= 17'(SPAWN_GAP)) ? 16'(SPAWN_GAP) : gap_sum_s[15:0];
                    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5]};
                    state_d   = ST_SPAWN;
                end
                ST_SPAWN: begin
                    if ((gap_q >= 16'(SPAWN_GAP)) && has_free_s) begin
                        valid_d[first_free_s] = 1'b1;
                        y_d[first_free_s]     = 10'd0;
                        lane_d[first_free_s]  = lane_pick_s;
                        gap_d                 = 16'd0;
                        last_lane_d           = lane_pick_s;
                        spawn_d               = 1'b1;
`ifdef DOUBLE_SPAWN_EN
                        if (has_second_s) begin
                            valid_d[second_free_s] = 1'b1;
                            y_d[second_free_s]     = 10'd0;
                            lane_d[second_free_s]  = lane2_s;
                        end else begin
                            spawn_d = 1'b1;
                        end
`endif
                    end else begin
                        gap_d = gap_q;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= {NUM_SLOTS{1'b0}};
            lane_q      <= {(2*NUM_SLOTS){1'b0}};
            y_q         <= {(10*NUM_SLOTS){1'b0}};
            score_q     <= 16'd0;
            level_q     <= 4'd0;
            gap_q       <= 16'(SPAWN_GAP);
            lfsr_q      <= LFSR_SEED;
            last_lane_q <= 2'd1;
            busy_q      <= 1'b0;
            spawn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            y_q         <= y_d;
            score_q     <= score_d;
            level_q     <= level_d;
            gap_q       <= gap_d;
            lfsr_q      <= lfsr_d;
            last_lane_q <= last_lane_d;
            busy_q      <= busy_d;
            spawn_q     <= spawn_d;
        end
    end

    assign obs_valid = valid_q;
    assign obs_lane  = lane_q;
    assign obs_y     = y_q;
    assign score     = score_q;
    assign level     = level_q;
    assign busy      = busy_q;
    assign spawn_pls = spawn_q;
endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb_obstacle_spawn_scheduler: randomized bench for obstacle_spawn_scheduler with a
// per-obstacle reference model (integer positions, lowest-free-slot allocation).
module tb_obstacle_spawn_scheduler;
    localparam int NS    = 4;
    localparam int STEP0 = 4;
    localparam int GAP   = 120;
    localparam int YLIM  = 560;
    localparam int PPL   = 8;
    localparam int MAXL  = 8;

    logic            clk = 1'b0;
    logic            rst_n, tick, run, clear;
    logic [NS-1:0]   obs_valid;
    logic [2*NS-1:0] obs_lane;
    logic [10*NS-1:0] obs_y;
    logic [15:0]     score;
    logic [3:0]      level;
    logic            busy, spawn_pls;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_valid[NS];
    int       m_y[NS];
    int       m_lane[NS];
    int       m_score, m_level, m_gap, m_last;
    logic [7:0] m_lfsr;
    bit       m_spawned;

    obstacle_spawn_scheduler #(
        .NUM_SLOTS(NS), .Y_STEP_INIT(STEP0), .SPAWN_GAP(GAP), .Y_LIMIT(YLIM),
        .PTS_PER_LVL(PPL), .MAX_LEVEL(MAXL), .LFSR_SEED(8'hAC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clear(clear),
        .obs_valid(obs_valid), .obs_lane(obs_lane), .obs_y(obs_y),
        .score(score), .level(level), .busy(busy), .spawn_pls(spawn_pls)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0; m_y[i] = 0; m_lane[i] = 0;
        end
        m_score = 0; m_level = 0; m_gap = GAP; m_lfsr = 8'hAC; m_last = 1; m_spawned = 0;
    endtask

    task automatic m_advance();
        int step, ret;
        step = STEP0 + m_level;
        ret  = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] != 0) begin
                m_y[i] += step;
                if (m_y[i] >= YLIM) begin
                    m_valid[i] = 0; m_y[i] = 0; ret++;
                end
            end
        end
        m_score = (m_score + ret > 65535) ? 65535 : m_score + ret;
        m_level = m_score / PPL;
        if (m_level > MAXL) m_level = MAXL;
        m_gap = (m_gap + step > GAP) ? GAP : m_gap + step;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5]};
    endtask

    task automatic m_spawn();
        int f, r, lane;
        m_spawned = 0;
        f = -1;
        for (int i = 0; i < NS; i++) if (m_valid[i] == 0 && f < 0) f = i;
        if (m_gap >= GAP && f >= 0) begin
            r = int'(m_lfsr[1:0]);
            lane = (r < 3) ? r : (m_last + 1) % 3;
            m_valid[f] = 1; m_y[f] = 0; m_lane[f] = lane;
            m_gap = 0; m_last = lane; m_spawned = 1;
`ifdef DOUBLE_SPAWN_EN
            f = -1;
            for (int i = 0; i < NS; i++) if (m_valid[i] == 0 && f < 0) f = i;
            if (f >= 0) begin
                m_valid[f] = 1; m_y[f] = 0;
                m_lane[f] = (lane + 1 + int'(m_lfsr[2])) % 3;
            end
`endif
        end
    endtask

    function automatic logic [NS-1:0] exp_valid();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = (m_valid[i] != 0);
        return v;
    endfunction

    function automatic logic [2*NS-1:0] exp_lane();
        logic [2*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[2*i +: 2] = 2'(m_lane[i]);
        return v;
    endfunction

    function automatic logic [10*NS-1:0] exp_y();
        logic [10*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(m_y[i]);
        return v;
    endfunction

    // One tick attempt; starts and ends on a falling edge, model updated on accept.
    task automatic run_tick(input bit r, input bit noise);
        tick = 1'b1; run = r;
        @(negedge clk);
        if (r) begin
            tick = noise; run = 1'($urandom_range(0, 1));
        end else begin
            tick = 1'b0;
        end
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        if (r) begin
            m_advance();
            m_spawn();
        end else begin
            m_spawned = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (obs_valid !== exp_valid()) begin bad++; $display("FAIL reset_valid got=%b want=%b", obs_valid, exp_valid()); end
        total++; if (obs_y !== exp_y() || obs_lane !== exp_lane()) begin bad++; $display("FAIL reset_pos got_y=%h got_lane=%b", obs_y, obs_lane); end
        total++; if (score !== 16'd0 || level !== 4'd0) begin bad++; $display("FAIL reset_score got=%0d/%0d want=0/0", score, level); end
        total++; if (busy !== 1'b0 || spawn_pls !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", busy, spawn_pls); end
    endtask

    task automatic test_first_spawn();
        tick = 1'b1; run = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        total++; if (busy !== 1'b1 || spawn_pls !== 1'b0) begin bad++; $display("FAIL fs_k1 busy=%b spawn=%b want=10", busy, spawn_pls); end
        @(negedge clk);
        m_advance();
        total++; if (busy !== 1'b1 || obs_valid !== exp_valid() || score !== 16'(m_score)) begin bad++; $display("FAIL fs_k2 busy=%b valid=%b score=%0d", busy, obs_valid, score); end
        @(negedge clk);
        m_spawn();
        total++; if (busy !== 1'b0 || spawn_pls !== 1'b1) begin bad++; $display("FAIL fs_k3 busy=%b spawn=%b want=01", busy, spawn_pls); end
        total++; if (obs_valid !== exp_valid() || obs_lane !== exp_lane() || obs_y !== exp_y()) begin bad++; $display("FAIL fs_slot valid=%b lane=%b want %b %b", obs_valid, obs_lane, exp_valid(), exp_lane()); end
        @(negedge clk);
        total++; if (spawn_pls !== 1'b0) begin bad++; $display("FAIL fs_pulse got=%b want=0", spawn_pls); end
    endtask

    task automatic test_pool_full();
        int spawns;
        spawns = 1;
        for (int n = 2; n <= 141; n++) begin
            run_tick(1'b1, 1'(n % 2));
            if (spawn_pls === 1'b1) spawns++;
            total++; if (obs_valid !== exp_valid()) begin bad++; $display("FAIL pool_valid n=%0d got=%b want=%b", n, obs_valid, exp_valid()); end
            total++; if (obs_y !== exp_y() || obs_lane !== exp_lane()) begin bad++; $display("FAIL pool_pos n=%0d got=%h want=%h", n, obs_y, exp_y()); end
            total++; if (score !== 16'(m_score) || spawn_pls !== m_spawned) begin bad++; $display("FAIL pool_score n=%0d got=%0d/%b want=%0d/%b", n, score, spawn_pls, m_score, m_spawned); end
            if (n == 121) begin
                total++; if (spawn_pls !== 1'b0 || obs_valid !== 4'b1111) begin bad++; $display("FAIL pool_full_nospawn spawn=%b valid=%b", spawn_pls, obs_valid); end
            end
            if (n == 141) begin
                total++; if (score !== 16'd1 || spawn_pls !== 1'b1 || obs_valid !== 4'b1111 || obs_y[9:0] !== 10'd0) begin bad++; $display("FAIL pool_reuse score=%0d spawn=%b valid=%b y0=%0d", score, spawn_pls, obs_valid, obs_y[9:0]); end
            end
        end
        total++; if (spawns != 5) begin bad++; $display("FAIL pool_spawn_count got=%0d want=5", spawns); end
    endtask

    task automatic test_run_freeze();
        for (int n = 0; n < 6; n++) begin
            run_tick(1'b0, 1'b0);
            total++; if (obs_valid !== exp_valid() || obs_y !== exp_y() || obs_lane !== exp_lane()) begin bad++; $display("FAIL freeze_pos n=%0d got=%h want=%h", n, obs_y, exp_y()); end
            total++; if (score !== 16'(m_score) || busy !== 1'b0 || spawn_pls !== 1'b0) begin bad++; $display("FAIL freeze_flags n=%0d score=%0d busy=%b spawn=%b", n, score, busy, spawn_pls); end
        end
    endtask

    task automatic test_clear_mid_advance();
        tick = 1'b1; run = 1'b1;
        @(negedge clk);
        tick = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_reset();
        total++; if (obs_valid !== exp_valid() || obs_y !== exp_y() || obs_lane !== exp_lane()) begin bad++; $display("FAIL clear_pos valid=%b y=%h lane=%b", obs_valid, obs_y, obs_lane); end
        total++; if (score !== 16'd0 || level !== 4'd0 || busy !== 1'b0 || spawn_pls !== 1'b0) begin bad++; $display("FAIL clear_flags score=%0d level=%0d busy=%b spawn=%b", score, level, busy, spawn_pls); end
        run_tick(1'b1, 1'b0);
        total++; if (obs_valid !== exp_valid() || obs_lane !== exp_lane() || spawn_pls !== 1'b1) begin bad++; $display("FAIL clear_respawn valid=%b lane=%b spawn=%b want %b %b 1", obs_valid, obs_lane, spawn_pls, exp_valid(), exp_lane()); end
    endtask

    task automatic test_level_ramp();
        int n;
        n = 0;
        while (m_score < 72 && n < 6000) begin
            run_tick($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
            n++;
            total++; if (obs_valid !== exp_valid() || obs_y !== exp_y() || obs_lane !== exp_lane()) begin bad++; $display("FAIL ramp_pos n=%0d got=%h want=%h", n, obs_y, exp_y()); end
            total++; if (score !== 16'(m_score) || level !== 4'(m_level)) begin bad++; $display("FAIL ramp_score n=%0d got=%0d/%0d want=%0d/%0d", n, score, level, m_score, m_level); end
            total++; if (spawn_pls !== m_spawned || busy !== 1'b0) begin bad++; $display("FAIL ramp_flags n=%0d spawn=%b busy=%b want=%b0", n, spawn_pls, busy, m_spawned); end
            if (m_score >= 8 && m_score < 16) begin
                total++; if (level !== 4'd1) begin bad++; $display("FAIL ramp_level1 got=%0d want=1", level); end
            end
            if (m_score >= 64) begin
                total++; if (level !== 4'd8) begin bad++; $display("FAIL ramp_level_sat got=%0d want=8", level); end
            end
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        total++; if (m_score < 72) begin bad++; $display("FAIL ramp_budget score=%0d want>=72 after %0d ticks", m_score, n); end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_pool_full();
        test_run_freeze();
        test_clear_mid_advance();
        test_level_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
